// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: run/halt/step/dump controller for the MIPS pipeline.
//   Owns the global pipeline enable. It shares REGMEM read port 1 between the
//   ID stage and a GPR dump sequencer that streams beats over valid/ready.
//   It also counts the cycles in which the pipeline was enabled.
// Optional build macro: DUMP_CYCLES_EN appends one beat that carries cycle_count.
// Ports:
//   clk, reset                  clock, async active-high reset
//   cmd_valid/cmd_op/cmd_ready  host command channel (RUN/HALT/STEP/DUMP)
//   wb_halt                     HALT instruction present in MEM/WB
//   id_rs/id_rt -> rf_rs/rf_rt  REGMEM read addresses (rs arbitrated)
//   rf_data_1                   REGMEM port-1 read data (combinational)
//   pipe_enable                 global pipeline advance enable
//   dump_valid/ready/data/last  register dump stream
//   state                       current FSM state
//   cycle_count                 saturating enabled-cycle counter
module pipeline_debug_ctrl #(
    parameter int unsigned NB_DATA   = 32,
    parameter int unsigned NB_ADDR   = 5,
    parameter int unsigned N_REGS    = 32,
    parameter int unsigned NB_CYCLES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [1:0]           cmd_op,
    output logic                 cmd_ready,
    input  logic                 wb_halt,
    input  logic [NB_ADDR-1:0]   id_rs,
    input  logic [NB_ADDR-1:0]   id_rt,
    output logic [NB_ADDR-1:0]   rf_rs,
    output logic [NB_ADDR-1:0]   rf_rt,
    input  logic [NB_DATA-1:0]   rf_data_1,
    output logic                 pipe_enable,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic [NB_DATA-1:0]   dump_data,
    output logic                 dump_last,
    output logic [2:0]           state,
    output logic [NB_CYCLES-1:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_HALTED   = 3'd0,
        ST_RUNNING  = 3'd1,
        ST_STEP     = 3'd2,
        ST_DUMP_RD  = 3'd3,
        ST_DUMP_OUT = 3'd4,
        ST_FINISHED = 3'd5
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_HALT = 2'b01;
    localparam logic [1:0] OP_STEP = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

`ifdef DUMP_CYCLES_EN
    localparam int unsigned N_BEATS = N_REGS + 1;
`else
    localparam int unsigned N_BEATS = N_REGS;
`endif
    localparam int unsigned NB_IDX = $clog2(N_BEATS);
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(N_BEATS - 1);

    state_t              state_q;
    state_t              state_next;
    logic [NB_IDX-1:0]   dump_idx;
    logic                ret_finished;
    logic                cmd_fire;
    logic                in_dump;
    logic [NB_DATA-1:0]  beat_data;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign in_dump  = (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_OUT);
    assign state    = state_q;

    // Read port 1 belongs to the dump sequencer while the pipeline is frozen for a dump
    assign rf_rs = in_dump ? NB_ADDR'(dump_idx) : id_rs;
    assign rf_rt = id_rt;

    // Payload of the beat being read: a GPR, or the cycle counter on the extra beat
`ifdef DUMP_CYCLES_EN
    assign beat_data = (dump_idx == NB_IDX'(N_REGS)) ? NB_DATA'(cycle_count) : rf_data_1;
`else
    assign beat_data = rf_data_1;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_HALTED;
        else       state_q <= state_next;
    end

    // Next-state logic; wb_halt beats a simultaneous HALT command
    always_comb begin
        state_next = state_q;
        case (state_q)
            ST_HALTED: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_RUN)       state_next = ST_RUNNING;
                    else if (cmd_op == OP_STEP) state_next = ST_STEP;
                    else if (cmd_op == OP_DUMP) state_next = ST_DUMP_RD;
                end
            end
            ST_RUNNING: begin
                if (wb_halt)                             state_next = ST_FINISHED;
                else if (cmd_fire && cmd_op == OP_HALT)  state_next = ST_HALTED;
            end
            ST_STEP:     state_next = wb_halt ? ST_FINISHED : ST_HALTED;
            ST_DUMP_RD:  state_next = ST_DUMP_OUT;
            ST_DUMP_OUT: begin
                if (dump_ready) begin
                    if (dump_last) state_next = ret_finished ? ST_FINISHED : ST_HALTED;
                    else           state_next = ST_DUMP_RD;
                end
            end
            ST_FINISHED: begin
                if (cmd_fire && cmd_op == OP_DUMP) state_next = ST_DUMP_RD;
            end
            default:     state_next = ST_HALTED;
        endcase
    end

    // Moore outputs registered from the next state so they align with state_q
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_enable <= 1'b0;
            cmd_ready   <= 1'b1;
        end else begin
            pipe_enable <= (state_next == ST_RUNNING) || (state_next == ST_STEP);
            cmd_ready   <= (state_next == ST_HALTED) || (state_next == ST_RUNNING) ||
                           (state_next == ST_FINISHED);
        end
    end

    // Saturating count of enabled edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                   cycle_count <= '0;
        else if (pipe_enable && (cycle_count != '1)) cycle_count <= cycle_count + NB_CYCLES'(1);
    end

    // Dump sequencer: index, return target and the held output beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dump_idx     <= '0;
            ret_finished <= 1'b0;
            dump_valid   <= 1'b0;
            dump_data    <= '0;
            dump_last    <= 1'b0;
        end else begin
            if (!in_dump && state_next == ST_DUMP_RD)
                ret_finished <= (state_q == ST_FINISHED);
            if (state_q == ST_DUMP_RD) begin
                dump_data  <= beat_data;
                dump_valid <= 1'b1;
                dump_last  <= (dump_idx == LAST_IDX);
            end else if (state_q == ST_DUMP_OUT && dump_ready) begin
                dump_valid <= 1'b0;
                dump_last  <= 1'b0;
                dump_idx   <= dump_last ? '0 : dump_idx + NB_IDX'(1);
            end
        end
    end

endmodule
